// File: rtl/mtm_alu_serializer.sv
// Serial transmitter for the ALU result path: sends C as four data packets plus a
// CTL control packet (or only the control packet for an error) as 11-bit frames on sout.
module mtm_alu_serializer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] C_in,
  input  logic [7:0]  CTL_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        sout
);

  typedef enum logic [2:0] {IDLE, START, TYPE, DATA, STOP} state_t;

  localparam logic [7:0] BAUD_LAST = 8'(BIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  pkt_q, pkt_d;
  logic [31:0] c_q, c_d;
  logic [7:0]  ctl_q, ctl_d;
  logic        sout_q, sout_d;
  logic        ready_q, ready_d;
  logic [7:0]  curByte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      pkt_q   <= '0;
      c_q     <= '0;
      ctl_q   <= '0;
      sout_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      pkt_q   <= pkt_d;
      c_q     <= c_d;
      ctl_q   <= ctl_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
    end
  end

  // sout and ready_out are registered from the next state, so the start bit
  // appears on the accepting edge itself with no extra latency.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    pkt_d   = pkt_q;
    c_d     = c_q;
    ctl_d   = ctl_q;
    curByte = ctl_d;
    sout_d  = 1'b1;
    ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (valid_in && ready_q) begin
          state_d = START;
          c_d     = C_in;
          ctl_d   = CTL_in;
          pkt_d   = CTL_in[7] ? 3'd0 : 3'd4;
          bit_d   = '0;
        end
      end
      default: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          case (state_q)
            START: state_d = TYPE;
            TYPE: begin
              state_d = DATA;
              bit_d   = '0;
            end
            DATA: begin
              if (bit_q == 3'd7) state_d = STOP;
              else bit_d = bit_q + 3'd1;
            end
            STOP: begin
              // A nonzero count means data packets remain; the control packet goes last.
              if (pkt_q != 3'd0) begin
                pkt_d   = pkt_q - 3'd1;
                state_d = START;
              end else begin
                state_d = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
    endcase

    case (pkt_d)
      3'd4:    curByte = c_d[31:24];
      3'd3:    curByte = c_d[23:16];
      3'd2:    curByte = c_d[15:8];
      3'd1:    curByte = c_d[7:0];
      default: curByte = ctl_d;
    endcase

    case (state_d)
      START:   sout_d = 1'b0;
      TYPE:    sout_d = (pkt_d == 3'd0);
      DATA:    sout_d = curByte[3'd7 - bit_d];
      default: sout_d = 1'b1;
    endcase

    ready_d = (state_d == IDLE);
  end

  assign sout      = sout_q;
  assign ready_out = ready_q;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Self-checking bench for mtm_alu_serializer: expected line bits are queued when a
// frame is launched and compared cycle by cycle against sout.
module tb_mtm_alu_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cIn = '0, cIn4 = '0;
  logic [7:0]  ctlIn = '0, ctlIn4 = '0;
  logic        validIn = 1'b0, validIn4 = 1'b0;
  logic        readyOut, readyOut4;
  logic        soutOut, soutOut4;

  int checks = 0;
  int errors = 0;
  logic expQ[$];
  logic exp4Q[$];

  mtm_alu_serializer #(.BIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .C_in(cIn), .CTL_in(ctlIn), .valid_in(validIn),
    .ready_out(readyOut), .sout(soutOut)
  );

  mtm_alu_serializer #(.BIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .C_in(cIn4), .CTL_in(ctlIn4), .valid_in(validIn4),
    .ready_out(readyOut4), .sout(soutOut4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Builds the reference line waveform, one entry per clock cycle.
  function automatic void pushFrame(input bit toDut4, input logic [31:0] c,
                                    input logic [7:0] ctl, input int bc);
    logic [10:0] pkt;
    int nPkt;
    nPkt = ctl[7] ? 1 : 5;
    for (int p = 5 - nPkt; p < 5; p++) begin
      if (p < 4) pkt = {1'b0, 1'b0, c[31 - 8*p -: 8], 1'b1};
      else       pkt = {1'b0, 1'b1, ctl, 1'b1};
      for (int b = 10; b >= 0; b--)
        for (int r = 0; r < bc; r++)
          if (toDut4) exp4Q.push_back(pkt[b]);
          else        expQ.push_back(pkt[b]);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (soutOut !== 1'b1 || readyOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state: sout=%b ready=%b, required sout=1 ready=0", soutOut, readyOut);
      end
      checks++;
      if (soutOut4 !== 1'b1 || readyOut4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state4: sout=%b ready=%b, required sout=1 ready=0", soutOut4, readyOut4);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (readyOut !== 1'b1 || soutOut !== 1'b1 || readyOut4 !== 1'b1 || soutOut4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release: ready=%b sout=%b ready4=%b sout4=%b, required all 1",
               readyOut, soutOut, readyOut4, soutOut4);
    end
  endtask

  task automatic test_normal();
    logic e;
    int idx;
    cIn = 32'h12345678; ctlIn = 8'h35; validIn = 1'b1;
    pushFrame(1'b0, cIn, ctlIn, 1);
    tick();
    validIn = 1'b0;
    idx = 0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (soutOut !== e || readyOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL normal_bit%0d: sout=%b ready=%b, required sout=%b ready=0", idx, soutOut, readyOut, e);
      end
      idx++;
      tick();
    end
    checks++;
    if (soutOut !== 1'b1 || readyOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL normal_end: sout=%b ready=%b after %0d bits, required 1/1", soutOut, readyOut, idx);
    end
  endtask

  task automatic test_error();
    logic e;
    int idx;
    cIn = 32'hFFFFFFFF; ctlIn = 8'h93; validIn = 1'b1;
    pushFrame(1'b0, cIn, ctlIn, 1);
    tick();
    validIn = 1'b0;
    idx = 0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (soutOut !== e || readyOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL error_bit%0d: sout=%b ready=%b, required sout=%b ready=0", idx, soutOut, readyOut, e);
      end
      idx++;
      tick();
    end
    checks++;
    if (soutOut !== 1'b1 || readyOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL error_end: sout=%b ready=%b after %0d bits, required 1/1", soutOut, readyOut, idx);
    end
  endtask

  task automatic test_bit_cycles4();
    logic e;
    int idx;
    cIn4 = 32'h12345678; ctlIn4 = 8'h35; validIn4 = 1'b1;
    pushFrame(1'b1, cIn4, ctlIn4, 4);
    tick();
    validIn4 = 1'b0;
    idx = 0;
    while (exp4Q.size() > 0) begin
      e = exp4Q.pop_front();
      checks++;
      if (soutOut4 !== e || readyOut4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bc4_cycle%0d: sout=%b ready=%b, required sout=%b ready=0", idx, soutOut4, readyOut4, e);
      end
      idx++;
      tick();
    end
    checks++;
    if (soutOut4 !== 1'b1 || readyOut4 !== 1'b1 || idx != 220) begin
      errors++;
      $display("[TB] FAIL bc4_end: sout=%b ready=%b cycles=%0d, required 1/1 after 220", soutOut4, readyOut4, idx);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int idx;
    cIn = 32'h00000001; ctlIn = 8'h20; validIn = 1'b1;
    pushFrame(1'b0, cIn, ctlIn, 1);
    tick();
    cIn = 32'h80000000; ctlIn = 8'h40;
    for (int f = 0; f < 2; f++) begin
      idx = 0;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (soutOut !== e || readyOut !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_f%0d_bit%0d: sout=%b ready=%b, required sout=%b ready=0", f, idx, soutOut, readyOut, e);
        end
        idx++;
        tick();
      end
      checks++;
      if (soutOut !== 1'b1 || readyOut !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_gap%0d: sout=%b ready=%b, required 1/1", f, soutOut, readyOut);
      end
      if (f == 0) begin
        pushFrame(1'b0, 32'h80000000, 8'h40, 1);
        tick();
        validIn = 1'b0;
      end
    end
  endtask

  task automatic test_capture();
    logic e;
    int idx;
    cIn = 32'hCAFEF00D; ctlIn = 8'h1A; validIn = 1'b1;
    pushFrame(1'b0, cIn, ctlIn, 1);
    tick();
    validIn = 1'b0;
    idx = 0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (soutOut !== e || readyOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL capture_bit%0d: sout=%b ready=%b, required sout=%b ready=0", idx, soutOut, readyOut, e);
      end
      if (idx == 10) begin
        cIn = 32'hDEADBEEF; ctlIn = 8'h7F;
      end
      validIn = (idx == 20);
      idx++;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (soutOut !== 1'b1 || readyOut !== 1'b1) begin
        errors++;
        $display("[TB] FAIL capture_idle%0d: sout=%b ready=%b, required 1/1", i, soutOut, readyOut);
      end
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    logic e;
    cIn = 32'hA5A5A5A5; ctlIn = 8'h0F; validIn = 1'b1;
    pushFrame(1'b0, cIn, ctlIn, 1);
    tick();
    validIn = 1'b0;
    for (int idx = 0; idx < 20; idx++) begin
      e = expQ.pop_front();
      checks++;
      if (soutOut !== e) begin
        errors++;
        $display("[TB] FAIL midrst_bit%0d: sout=%b, required %b", idx, soutOut, e);
      end
      tick();
    end
    expQ.delete();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (soutOut !== 1'b1 || readyOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_hold%0d: sout=%b ready=%b, required sout=1 ready=0", i, soutOut, readyOut);
      end
      validIn = 1'b1;
    end
    rst = 1'b0;
    validIn = 1'b0;
    tick();
    checks++;
    if (readyOut !== 1'b1 || soutOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_release: ready=%b sout=%b, required 1/1", readyOut, soutOut);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (soutOut !== 1'b1 || readyOut !== 1'b1) begin
        errors++;
        $display("[TB] FAIL midrst_leftover%0d: sout=%b ready=%b, required 1/1", i, soutOut, readyOut);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_normal();
    test_error();
    test_bit_cycles4();
    test_back_to_back();
    test_capture();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
